// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared state encoding and defaults for the shift-and-add multiplier sequencer
package sequencer_pkg;

   localparam int SEQ_N_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_INIT  = 2'd1;
   localparam logic [1:0] ST_ADD   = 2'd2;
   localparam logic [1:0] ST_SHIFT = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      INIT  = ST_INIT,
      ADD   = ST_ADD,
      SHIFT = ST_SHIFT
   } state_t;

endpackage

// File: rtl/sequencer_if.sv
// rtl/sequencer_if.sv - control/status bundle between sequencer and datapath (done gated by SEQUENCER_DONE_PULSE_EN)
import sequencer_pkg::*;

interface sequencer_if #(parameter int N = SEQ_N_DEFAULT);

   logic         start;
   logic         Q0;
   logic         clear;
   logic         add;
   logic         shift;
   logic         ready;
   logic [N-1:0] count;
`ifdef SEQUENCER_DONE_PULSE_EN
   logic         done;

   modport master (output start, Q0, input clear, add, shift, ready, count, done);
   modport slave  (input start, Q0, output clear, add, shift, ready, count, done);
`else
   modport master (output start, Q0, input clear, add, shift, ready, count);
   modport slave  (input start, Q0, output clear, add, shift, ready, count);
`endif

endinterface

// File: rtl/sequencer.sv
// rtl/sequencer.sv - shift-and-add multiplier control FSM; SEQUENCER_DONE_PULSE_EN adds a done strobe
import sequencer_pkg::*;

module sequencer #(
   parameter int n = SEQ_N_DEFAULT
) (
   input  logic      clock,
   input  logic      reset,
   sequencer_if.slave bus
);

   state_t         state_q, state_d;
   logic [n-1:0]   count_q, count_d;
   logic           last_iter;

   assign last_iter = (int'(count_q) == n - 1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = INIT;
         end
         INIT: begin
            count_d = '0;
            state_d = ADD;
         end
         ADD: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            // Counter returns to zero on the final shift so IDLE always shows count = 0.
            if (last_iter) begin
               count_d = '0;
               state_d = IDLE;
            end else begin
               count_d = count_q + 1'b1;
               state_d = ADD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.clear = (state_q == INIT);
   assign bus.add   = (state_q == ADD) & bus.Q0;
   assign bus.shift = (state_q == SHIFT);
   assign bus.count = count_q;
`ifdef SEQUENCER_DONE_PULSE_EN
   assign bus.done  = (state_q == SHIFT) & last_iter;
`endif

endmodule

// File: tb/tb_sequencer.sv
// tb/tb_sequencer.sv - randomized scoreboard bench for the multiplier sequencer
`timescale 1ns/1ps
import sequencer_pkg::*;

module tb_sequencer;

   localparam int N = 4;

   typedef struct packed {
      logic         ready;
      logic         clear;
      logic         add;
      logic         shift;
      logic [N-1:0] count;
      logic         done;
   } obs_t;

   logic clock;
   logic reset;

   sequencer_if #(.N(N)) bus ();

   sequencer #(.n(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: an operation is a schedule of 2N+1 busy cycles,
   // phase 0 = clear, odd phases = add slots, even phases = shift slots.
   bit         model_valid = 1'b0;
   bit         busy        = 1'b0;
   int         phase       = 0;
   logic [3:0] pat         = 4'b1101;

   task automatic step(input bit st, input int q0_mode, input bit rst);
      obs_t e;
      bit   q;
      int   iter;
      @(negedge clock);
      iter = (phase - 1) / 2;
      case (q0_mode)
         0:       q = 1'b0;
         1:       q = 1'b1;
         2:       q = (busy && (phase % 2 == 1)) ? pat[iter] : 1'($urandom_range(0, 1));
         default: q = 1'($urandom_range(0, 1));
      endcase
      bus.start = st;
      bus.Q0    = q;
      reset     = rst;
      if (model_valid) begin
         e = '0;
         if (!busy) begin
            e.ready = 1'b1;
         end else if (phase == 0) begin
            e.clear = 1'b1;
         end else if (phase % 2 == 1) begin
            e.add   = q;
            e.count = N'((phase - 1) / 2);
         end else begin
            e.shift = 1'b1;
            e.count = N'(phase / 2 - 1);
`ifdef SEQUENCER_DONE_PULSE_EN
            e.done  = (phase == 2 * N);
`endif
         end
         exp_q.push_back(e);
      end
      if (rst) begin
         model_valid = 1'b1;
         busy        = 1'b0;
         phase       = 0;
      end else if (model_valid) begin
         if (!busy) begin
            if (st) begin
               busy  = 1'b1;
               phase = 0;
            end
         end else if (phase == 2 * N) begin
            busy = 1'b0;
         end else begin
            phase++;
         end
      end
   endtask

   task automatic run_op(input int q0_mode);
      step(1'b1, q0_mode, 1'b0);
      for (int i = 0; i < 40 && busy; i++) step(1'b0, q0_mode, 1'b0);
   endtask

   task automatic run_until_phase(input int target, input bit st_hold);
      for (int i = 0; i < 40 && !(busy && phase == target); i++) step(st_hold, 3, 1'b0);
   endtask

   initial begin : monitor
      obs_t e;
      obs_t got;
      forever begin
         @(negedge clock);
         #5;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = '0;
            got.ready = bus.ready;
            got.clear = bus.clear;
            got.add   = bus.add;
            got.shift = bus.shift;
            got.count = bus.count;
`ifdef SEQUENCER_DONE_PULSE_EN
            got.done  = bus.done;
`endif
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL outputs t=%0t got rdy=%b clr=%b add=%b sh=%b cnt=%0d done=%b want rdy=%b clr=%b add=%b sh=%b cnt=%0d done=%b",
                        $time, got.ready, got.clear, got.add, got.shift, got.count, got.done,
                        e.ready, e.clear, e.add, e.shift, e.count, e.done);
            end
         end
      end
   end

   initial begin : stimulus
      bus.start = 1'b0;
      bus.Q0    = 1'b0;
      reset     = 1'b1;

      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0);

      run_op(0);
      step(1'b0, 0, 1'b0);
      run_op(1);
      step(1'b0, 1, 1'b0);
      run_op(2);
      step(1'b0, 3, 1'b0);

      // start pulses while busy must be ignored
      step(1'b1, 3, 1'b0);
      run_until_phase(5, 1'b0);
      step(1'b1, 3, 1'b0);
      step(1'b1, 3, 1'b0);
      for (int i = 0; i < 40 && busy; i++) step(1'b0, 3, 1'b0);
      step(1'b0, 3, 1'b0);

      // back-to-back operations with start held
      for (int i = 0; i < 3 * (2 * N + 2); i++) step(1'b1, 3, 1'b0);
      for (int i = 0; i < 40 && busy; i++) step(1'b0, 3, 1'b0);

      // abort at count = 2
      step(1'b1, 3, 1'b0);
      run_until_phase(5, 1'b0);
      step(1'b0, 3, 1'b1);
      step(1'b0, 3, 1'b0);
      step(1'b1, 3, 1'b0);
      run_until_phase(6, 1'b0);
      step(1'b1, 3, 1'b1);
      step(1'b0, 3, 1'b0);

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 30), 3, ($urandom_range(0, 99) < 2));

      for (int i = 0; i < 3; i++) step(1'b0, 3, 1'b0);
      @(negedge clock);
      #6;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
